ahb_write_buffer: RTL and testbench

AHB_WRITE_BUFFER -- requirements
Module: ahb_write_buffer

---
 rtl/ahb_write_buffer.sv | 183 ++++++++++++++++++
 tb/tb_ahb_write_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_write_buffer.sv
// AHB-Lite single-entry posted-write buffer between an upstream master and a
// downstream SRAM controller. Writes complete upstream with zero wait states
// while the buffer is empty; reads wait for the buffered write to drain first.
`timescale 1ns/1ps
module ahb_write_buffer #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream slave port
  input  logic              s_hready,
  output logic              s_hready_resp,
  output logic              s_hresp,
  input  logic [W_ADDR-1:0] s_haddr,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  input  logic [2:0]        s_hsize,
  input  logic [3:0]        s_hprot,
  input  logic [2:0]        s_hburst,
  input  logic              s_hmastlock,
  input  logic [W_DATA-1:0] s_hwdata,
  output logic [W_DATA-1:0] s_hrdata,
  // downstream master port
  input  logic              m_hready,
  input  logic              m_hresp,
  output logic [W_ADDR-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  output logic [3:0]        m_hprot,
  output logic [2:0]        m_hburst,
  output logic              m_hmastlock,
  output logic [W_DATA-1:0] m_hwdata,
  input  logic [W_DATA-1:0] m_hrdata,
  output logic              busy
);

  typedef enum logic [1:0] {U_IDLE, U_WRITE, U_READ} u_state_t;
  typedef enum logic [2:0] {M_IDLE, M_APH_W, M_DPH_W, M_APH_R, M_DPH_R} m_state_t;

  u_state_t u_state, u_state_nxt;
  m_state_t m_state, m_state_nxt;

  // aphase register
  logic [W_ADDR-1:0] ar_addr;
  logic              ar_write;
  logic [2:0]        ar_size;
  logic [3:0]        ar_prot;

  // write buffer
  logic              wb_valid;
  logic [W_ADDR-1:0] wb_addr;
  logic [2:0]        wb_size;
  logic [3:0]        wb_prot;
  logic [W_DATA-1:0] wb_data;

  logic aph_accept, wb_drain, wb_free, wb_cap, rd_done, rd_pending, wb_valid_nxt;
  logic unused_inputs;

  assign aph_accept   = s_hready && s_htrans[1];
  assign wb_drain     = (m_state == M_DPH_W) && m_hready;
  assign wb_free      = !wb_valid || wb_drain;
  assign wb_cap       = (u_state == U_WRITE) && wb_free;
  assign rd_done      = (m_state == M_DPH_R) && m_hready;
  assign rd_pending   = (u_state == U_READ);
  assign wb_valid_nxt = wb_cap || (wb_valid && !wb_drain);

  assign s_hresp       = 1'b0;
  assign m_hburst      = 3'b000;
  assign m_hmastlock   = 1'b0;
  assign unused_inputs = ^{s_hburst, s_hmastlock, m_hresp};

  // Upstream response: writes stall only on a full buffer, reads until downstream data returns
  always_comb begin
    s_hready_resp = 1'b1;
    s_hrdata      = '0;
    case (u_state)
      U_WRITE: s_hready_resp = wb_free;
      U_READ: begin
        s_hready_resp = rd_done;
        if (rd_done) s_hrdata = m_hrdata;
      end
      default: s_hready_resp = 1'b1;
    endcase
  end

  // Next-state logic for both sides; buffered writes always go out before reads
  always_comb begin
    u_state_nxt = u_state;
    m_state_nxt = m_state;
    if (s_hready) begin
      if (!s_htrans[1])  u_state_nxt = U_IDLE;
      else if (s_hwrite) u_state_nxt = U_WRITE;
      else               u_state_nxt = U_READ;
    end
    case (m_state)
      M_IDLE: begin
        if (wb_valid || wb_cap)                          m_state_nxt = M_APH_W;
        else if (rd_pending || (aph_accept && !s_hwrite)) m_state_nxt = M_APH_R;
      end
      M_APH_W: if (m_hready) m_state_nxt = M_DPH_W;
      M_DPH_W: if (m_hready) m_state_nxt = wb_cap ? M_APH_W : M_IDLE;
      M_APH_R: if (m_hready) m_state_nxt = M_DPH_R;
      M_DPH_R: if (m_hready) m_state_nxt = M_IDLE;
      default: m_state_nxt = M_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_state <= U_IDLE;
      m_state <= M_IDLE;
    end else begin
      u_state <= u_state_nxt;
      m_state <= m_state_nxt;
    end
  end

  // Capture the accepted upstream address phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_addr  <= '0;
      ar_write <= 1'b0;
      ar_size  <= 3'b000;
      ar_prot  <= 4'b0000;
    end else if (aph_accept) begin
      ar_addr  <= s_haddr;
      ar_write <= s_hwrite;
      ar_size  <= s_hsize;
      ar_prot  <= s_hprot;
    end
  end

  // Posted-write buffer: fill on upstream write dphase, empty on downstream dphase completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_size  <= 3'b000;
      wb_prot  <= 4'b0000;
      wb_data  <= '0;
    end else begin
      wb_valid <= wb_valid_nxt;
      if (wb_cap) begin
        wb_addr <= ar_addr;
        wb_size <= ar_size;
        wb_prot <= ar_prot;
        wb_data <= s_hwdata;
      end
    end
  end

  // Downstream bus outputs; address fields hold their last value outside aphase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_htrans <= 2'b00;
      m_haddr  <= '0;
      m_hwrite <= 1'b0;
      m_hsize  <= 3'b000;
      m_hprot  <= 4'b0000;
      m_hwdata <= '0;
      busy     <= 1'b0;
    end else begin
      m_htrans <= ((m_state_nxt == M_APH_W) || (m_state_nxt == M_APH_R)) ? 2'b10 : 2'b00;
      busy     <= wb_valid_nxt || (m_state_nxt != M_IDLE);
      if (m_state_nxt == M_APH_W) begin
        m_hwrite <= 1'b1;
        m_haddr  <= wb_cap ? ar_addr : wb_addr;
        m_hsize  <= wb_cap ? ar_size : wb_size;
        m_hprot  <= wb_cap ? ar_prot : wb_prot;
      end else if (m_state_nxt == M_APH_R) begin
        m_hwrite <= rd_pending ? ar_write : s_hwrite;
        m_haddr  <= rd_pending ? ar_addr  : s_haddr;
        m_hsize  <= rd_pending ? ar_size  : s_hsize;
        m_hprot  <= rd_pending ? ar_prot  : s_hprot;
      end
      if (m_state_nxt == M_DPH_W) m_hwdata <= wb_data;
    end
  end

endmodule

// File: tb/tb_ahb_write_buffer.sv
// Bench for ahb_write_buffer: pipelined upstream master, wait-state-programmable
// downstream slave with memory, and a scoreboard of expected downstream transfers.
`timescale 1ns/1ps
module tb_ahb_write_buffer;

  logic        clk, rst_n;
  logic        s_hready, s_hready_resp, s_hresp;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [3:0]  s_hprot;
  logic [2:0]  s_hburst;
  logic        s_hmastlock;
  logic [31:0] s_hwdata, s_hrdata;
  logic        m_hready, m_hresp;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [3:0]  m_hprot;
  logic [2:0]  m_hburst;
  logic        m_hmastlock;
  logic [31:0] m_hwdata, m_hrdata;
  logic        busy;

  ahb_write_buffer #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_hready(s_hready), .s_hready_resp(s_hready_resp), .s_hresp(s_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hprot(s_hprot), .s_hburst(s_hburst), .s_hmastlock(s_hmastlock),
    .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hprot(m_hprot), .m_hburst(m_hburst),
    .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-slave system: bus HREADY is our own response
  assign s_hready = s_hready_resp;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_waits;
  } txn_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } ds_t;

  txn_t        txns[8];
  ds_t         ds_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] model[256];

  // downstream slave
  int          dph_waits = 0;
  logic        force_wait = 1'b0;
  logic        in_dph = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] dph_addr = '0;
  logic        dph_wr = 1'b0;
  logic [31:0] smem[256];
  logic [255:0] wr_flag;
  logic [31:0] mon_wdata = '0;

  assign m_hresp  = 1'b0;
  assign m_hready = !force_wait && (!in_dph || wait_cnt == 0);
  assign m_hrdata = (in_dph && !dph_wr) ?
                    (wr_flag[dph_addr[9:2]] ? smem[dph_addr[9:2]] : (32'hCAFEF00D ^ (dph_addr - 32'h40))) :
                    32'h0;

  // Slave: track dphase, insert wait states, store written data
  always @(posedge clk) begin
    if (!rst_n) wr_flag <= '0;
    if (in_dph && m_hready && dph_wr) begin
      smem[dph_addr[9:2]]    <= m_hwdata;
      wr_flag[dph_addr[9:2]] <= 1'b1;
    end
    if (m_htrans[1] && m_hready) begin
      in_dph   <= 1'b1;
      wait_cnt <= dph_waits;
      dph_addr <= m_haddr;
      dph_wr   <= m_hwrite;
    end else if (in_dph && m_hready) begin
      in_dph <= 1'b0;
    end else if (in_dph) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  // Scoreboard: every downstream transfer must match the next expected one, in order
  always @(negedge clk) begin
    if (rst_n && m_htrans[1] && m_hready) begin
      if (ds_q.size() == 0) begin
        check("ds_unexpected", {m_hwrite, m_haddr}, 0);
      end else begin
        ds_t e;
        e = ds_q.pop_front();
        check("ds_addr", m_haddr, e.addr);
        check("ds_write", m_hwrite, e.write);
        check("ds_size", m_hsize, 3'd2);
        mon_wdata <= e.data;
      end
    end
    if (rst_n && in_dph && m_hready && dph_wr) check("ds_wdata", m_hwdata, mon_wdata);
  end

  task automatic set_txn(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int ew);
    txns[i].write = w; txns[i].addr = a; txns[i].data = d; txns[i].exp_waits = ew;
  endtask

  // Pipelined upstream master: runs txns[0..n-1], checks wait states and read data
  task automatic run_seq(input int n);
    int   idx = 0;
    bit   dv = 0;
    txn_t dph;
    int   waits = 0;
    int   cyc = 0;
    bit   rdy;
    while ((idx < n || dv) && cyc < 200) begin
      if (idx < n) begin
        s_htrans = 2'b10; s_haddr = txns[idx].addr; s_hwrite = txns[idx].write;
      end else begin
        s_htrans = 2'b00;
      end
      @(negedge clk);
      rdy = s_hready_resp;
      if (dv && rdy) begin
        if (dph.exp_waits >= 0) check("up_waits", waits, dph.exp_waits);
        if (!dph.write) check("up_rdata", s_hrdata, rd_q.pop_front());
        dv = 0;
      end else if (dv) begin
        waits++;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy && idx < n) begin
        dph = txns[idx]; dv = 1; waits = 0; idx++;
        if (dph.write) begin
          s_hwdata = dph.data;
          model[dph.addr[9:2]] = dph.data;
          ds_q.push_back('{write: 1'b1, addr: dph.addr, data: dph.data});
        end else begin
          rd_q.push_back(model[dph.addr[9:2]]);
          ds_q.push_back('{write: 1'b0, addr: dph.addr, data: 32'h0});
        end
      end
    end
    s_htrans = 2'b00;
    check("seq_done", {idx == n, dv}, {1'b1, 1'b0});
  endtask

  task automatic idle_cycles(input int n);
    s_htrans = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {s_hready_resp, s_hresp, m_htrans, m_hwrite, busy, m_hsize, m_hprot},
          {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 4'b0000});
    check({tag, "_addr"}, m_haddr, 32'h0);
    check({tag, "_data"}, {m_hwdata, s_hrdata}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int hits;
    for (int i = 0; i < 256; i++) model[i] = 32'hCAFEF00D ^ (32'(i * 4) - 32'h40);
    rst_n = 1'b0;
    s_haddr = '0; s_htrans = 2'b00; s_hwrite = 1'b0; s_hsize = 3'd2; s_hprot = 4'b0011;
    s_hburst = 3'b000; s_hmastlock = 1'b0; s_hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE/BUSY upstream traffic leaves everything quiet
    for (int i = 0; i < 6; i++) begin
      s_htrans = (i % 2 == 0) ? 2'b00 : 2'b01;
      s_haddr = $urandom; s_hwrite = 1'($urandom); s_hburst = 3'($urandom);
      @(negedge clk);
      check("idle_quiet", {s_hready_resp, m_htrans, busy}, {1'b1, 2'b00, 1'b0});
      @(posedge clk); #1;
    end

    // single write: zero waits, aphase next cycle, data the cycle after
    dph_waits = 0;
    set_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 0);
    run_seq(1);
    @(negedge clk);
    check("wr_aph", {m_htrans, m_haddr}, {2'b10, 32'h100});
    @(negedge clk);
    check("wr_dph", {m_htrans, m_hwdata}, {2'b00, 32'hDEADBEEF});
    idle_cycles(4);

    // back-to-back writes with slow downstream: second stalls for aphase + 3 waits
    dph_waits = 3;
    set_txn(0, 1'b1, 32'h104, 32'h11111111, 0);
    set_txn(1, 1'b1, 32'h108, 32'h22222222, 4);
    run_seq(2);
    idle_cycles(10);

    // write then read of the same address: read issued only after the write drains
    dph_waits = 0;
    set_txn(0, 1'b1, 32'h200, 32'h12345678, 0);
    set_txn(1, 1'b0, 32'h200, 32'h0, 4);
    run_seq(2);
    idle_cycles(4);

    // idle read with a 2-cycle downstream dphase
    dph_waits = 1;
    set_txn(0, 1'b0, 32'h40, 32'h0, 2);
    run_seq(1);
    idle_cycles(4);

    // mixed traffic, ordering and data checked by the scoreboard
    set_txn(0, 1'b1, 32'h10, 32'hA1A1A1A1, -1);
    set_txn(1, 1'b0, 32'h10, 32'h0, -1);
    set_txn(2, 1'b1, 32'h14, 32'hB2B2B2B2, -1);
    set_txn(3, 1'b1, 32'h18, 32'hC3C3C3C3, -1);
    set_txn(4, 1'b0, 32'h14, 32'h0, -1);
    set_txn(5, 1'b0, 32'h44, 32'h0, -1);
    run_seq(6);
    idle_cycles(10);
    check("drained", busy, 1'b0);

    // reset while a buffered write is stuck in downstream aphase
    dph_waits = 0;
    force_wait = 1'b1;
    set_txn(0, 1'b1, 32'h300, 32'h55AA55AA, 0);
    run_seq(1);
    @(negedge clk);
    check("stuck_aph", {busy, m_htrans, m_haddr}, {1'b1, 2'b10, 32'h300});
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_wait = 1'b0;
    ds_q.delete();
    @(negedge clk);
    check_reset_vals("midrst");
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_htrans != 2'b00 || busy) hits++;
    end
    check("no_write_after_rst", hits, 0);

    check("ds_q_empty", ds_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
